// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with a memory-ready handshake and an illegal-opcode exception path.
module mc_controller #(
    parameter bit EXC_ON_BAD_FUNCT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic [2:0] pcsrc,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       exc,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // R-type functions the datapath ALU implements: add, sub, and, or, slt.
    localparam int N_FUNCT = 5;
    localparam logic [5:0] SUPPORTED_FUNCT [N_FUNCT] = '{
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010
    };

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BREX    = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_JREX    = 4'd12,
        S_EXC     = 4'd13,
        S_ILL14   = 4'd14,
        S_ILL15   = 4'd15
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [N_FUNCT-1:0] funct_hit;
    logic               funct_ok;

    generate
        for (genvar gi = 0; gi < N_FUNCT; gi++) begin : g_funct
            assign funct_hit[gi] = (funct == SUPPORTED_FUNCT[gi]);
        end
    endgenerate

    assign funct_ok = |funct_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR)
                            state_next = S_JREX;
                        else if (EXC_ON_BAD_FUNCT && !funct_ok)
                            state_next = S_EXC;
                        else
                            state_next = S_RTYPEEX;
                    end
                    OP_BEQ, OP_BNE: state_next = S_BREX;
                    OP_ADDI:        state_next = S_ADDIEX;
                    OP_J:           state_next = S_JEX;
                    default:        state_next = S_EXC;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_RTYPEWB: state_next = S_FETCH;
            S_BREX:    state_next = S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
            S_JEX:     state_next = S_FETCH;
            S_JREX:    state_next = S_FETCH;
            S_EXC:     state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcen     = 1'b0;
        pcsrc    = 3'b000;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        exc      = 1'b0;
        state    = state_reg;
        case (state_reg)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BREX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 3'b001;
                pcen    = (op == OP_BNE) ? ~zero : zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc = 3'b010;
                pcen  = 1'b1;
            end
            S_JREX: begin
                pcsrc = 3'b011;
                pcen  = 1'b1;
            end
            S_EXC: begin
                pcsrc = 3'b100;
                pcen  = 1'b1;
                exc   = 1'b1;
            end
            default: begin
            end
        endcase
        // Reset must suppress every strobe immediately, before the state register clears.
        if (!rst_n) begin
            pcen     = 1'b0;
            pcsrc    = 3'b000;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            aluop    = 2'b00;
            exc      = 1'b0;
            state    = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: per-instruction state paths and
// per-state output expectations are derived from the instruction-level behaviour.
module tb_mc_controller;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic [2:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       exc;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .pcsrc(pcsrc), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .exc(exc), .state(state)
    );

    // Observed bundle: {state, pcen, pcsrc, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, aluop, exc}
    function automatic logic [19:0] observed();
        return {state, pcen, pcsrc, iord, memwrite, irwrite, regwrite,
                regdst, memtoreg, alusrca, alusrcb, aluop, exc};
    endfunction

    function automatic logic [19:0] expect_vec(input logic rn, input int st,
                                               input logic mr, input logic z,
                                               input logic [5:0] opc);
        logic [3:0] s4;
        logic       e_pcen, e_iord, e_mw, e_ir, e_rw, e_rd, e_m2r, e_sa, e_exc;
        logic [2:0] e_pcsrc;
        logic [1:0] e_sb, e_aop;
        s4 = st[3:0];
        {e_pcen, e_iord, e_mw, e_ir, e_rw, e_rd, e_m2r, e_sa, e_exc} = '0;
        e_pcsrc = 3'd0; e_sb = 2'd0; e_aop = 2'd0;
        if (!rn) return 20'd0;
        case (st)
            0:  begin e_sb = 2'b01; e_ir = mr; e_pcen = mr; end
            1:  e_sb = 2'b11;
            2:  begin e_sa = 1'b1; e_sb = 2'b10; end
            3:  e_iord = 1'b1;
            4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
            5:  begin e_iord = 1'b1; e_mw = 1'b1; end
            6:  begin e_sa = 1'b1; e_aop = 2'b10; end
            7:  begin e_rd = 1'b1; e_rw = 1'b1; end
            8:  begin e_sa = 1'b1; e_aop = 2'b01; e_pcsrc = 3'b001;
                      e_pcen = (opc == OP_BNE) ? ~z : z; end
            9:  begin e_sa = 1'b1; e_sb = 2'b10; end
            10: e_rw = 1'b1;
            11: begin e_pcsrc = 3'b010; e_pcen = 1'b1; end
            12: begin e_pcsrc = 3'b011; e_pcen = 1'b1; end
            13: begin e_pcsrc = 3'b100; e_pcen = 1'b1; e_exc = 1'b1; end
            default: ;
        endcase
        return {s4, e_pcen, e_pcsrc, e_iord, e_mw, e_ir, e_rw, e_rd, e_m2r,
                e_sa, e_sb, e_aop, e_exc};
    endfunction

    // One full instruction from FETCH; wait_cnt<0 randomizes mem_ready stalls, zmode<0 randomizes zero.
    task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input int wait_cnt, input int zmode);
        int path[$];
        int cycles = 0;
        int errs = 0;
        logic [19:0] obs, expv;
        path = '{0, 1};
        if (opc == OP_LW)                          path = '{0, 1, 2, 3, 4};
        else if (opc == OP_SW)                     path = '{0, 1, 2, 5};
        else if (opc == OP_RTYPE && fn == FN_JR)   path.push_back(12);
        else if (opc == OP_RTYPE)                  path = '{0, 1, 6, 7};
        else if (opc == OP_BEQ || opc == OP_BNE)   path.push_back(8);
        else if (opc == OP_ADDI)                   path = '{0, 1, 9, 10};
        else if (opc == OP_J)                      path.push_back(11);
        else                                       path.push_back(13);
        foreach (path[i]) begin
            int st = path[i];
            bit waitable = (st == 0 || st == 3 || st == 5);
            int nw = 0;
            if (waitable) nw = (wait_cnt < 0) ? int'($urandom_range(0, 3)) : wait_cnt;
            for (int w = 0; w <= nw; w++) begin
                mem_ready = waitable ? (w == nw) : 1'($urandom_range(0, 1));
                zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
                op        = opc;
                funct     = fn;
                @(negedge clk);
                vectors++;
                cycles++;
                obs  = observed();
                expv = expect_vec(1'b1, st, mem_ready, zero, opc);
                if (obs !== expv) begin
                    miscompares++;
                    errs++;
                    $display("FAIL %s state%0d cycle%0d: got %05h expected %05h",
                             name, st, cycles, obs, expv);
                end
                @(posedge clk);
                #1;
            end
        end
        $display("instr %-8s op=%06b funct=%06b cycles=%0d errors=%0d", name, opc, fn, cycles, errs);
    endtask

    task automatic test_reset();
        logic [19:0] obs, expv;
        rst_n = 1'b0; op = OP_SW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (observed() !== 20'd0) begin
                miscompares++;
                $display("FAIL reset_init: got %05h expected 00000", observed());
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        // Walk a store into MEMWR and stall it there.
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        obs = observed(); expv = expect_vec(1'b1, 5, 1'b0, zero, OP_SW);
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL reset_memwr_entry: got %05h expected %05h", obs, expv);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (observed() !== 20'd0 || memwrite !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold%0d: got %05h expected 00000", i, observed());
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        obs = observed(); expv = expect_vec(1'b1, 0, 1'b0, zero, OP_SW);
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL reset_release: got %05h expected %05h", obs, expv);
        end
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_single_cycle_reset();
        logic [19:0] obs, expv;
        op = OP_LW; funct = 6'd0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        obs = observed(); expv = expect_vec(1'b1, 3, 1'b0, zero, OP_LW);
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL rst1_memrd: got %05h expected %05h", obs, expv);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        obs = observed(); expv = expect_vec(1'b1, 0, 1'b0, zero, OP_LW);
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL rst1_fetch: got %05h expected %05h", obs, expv);
        end
        @(posedge clk); #1;
        $display("test_single_cycle_reset done");
    endtask

    task automatic test_lw();
        run_instr("lw", OP_LW, 6'd0, 0, -1);
    endtask

    task automatic test_sw_wait();
        run_instr("sw_wait2", OP_SW, 6'd0, 2, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", OP_BEQ, 6'd0, 0, 1);
        run_instr("beq_z0", OP_BEQ, 6'd0, 0, 0);
        run_instr("bne_z1", OP_BNE, 6'd0, 0, 1);
        run_instr("bne_z0", OP_BNE, 6'd0, 0, 0);
    endtask

    task automatic test_jump();
        run_instr("j", OP_J, 6'd0, 0, -1);
        run_instr("jr", OP_RTYPE, FN_JR, 0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 6'd0, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_instr("add", OP_RTYPE, FN_ADD, 0, -1);
        run_instr("addi", OP_ADDI, 6'd0, 0, -1);
        run_instr("lw", OP_LW, 6'd0, 1, -1);
        run_instr("sw", OP_SW, 6'd0, 0, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] opc, fn;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
        for (int n = 0; n < 60; n++) begin
            int k = int'($urandom_range(0, 7));
            opc = (k == 7) ? 6'($urandom_range(0, 63)) : ops[k];
            fn  = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom_range(0, 63));
            run_instr("random", opc, fn, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jump();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS main controller: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, driving every datapath enable and mux select. It sits directly upstream of the five-way next-PC mux and supplies its 3-bit `pcsrc` select and the PC write enable. It also adds a memory-ready handshake and an illegal-opcode exception path.

## Interface
Parameters:
- `EXC_ON_BAD_FUNCT`, default 0: when 1, an R-type instruction with an unsupported funct also enters EXC.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `op`  in  6  opcode from the instruction register, stable from DECODE until return to FETCH.
- `funct`  in  6  funct field from the instruction register.
- `zero`  in  1  ALU zero flag, combinational from the current ALU operation.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pcen`  out  1  PC register write enable.
- `pcsrc`  out  3  next-PC mux select: 000 = ALU result (PC+4), 001 = ALUOut (branch target), 010 = jump target, 011 = rs (jr), 100 = exception vector.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  instruction register load.
- `regwrite`  out  1  register file write.
- `regdst`  out  1  destination register select: 1 = rd, 0 = rt.
- `memtoreg`  out  1  writeback data select: 1 = memory data, 0 = ALUOut.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = rs.
- `alusrcb`  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `aluop`  out  2  ALU decode class: 00 = add, 01 = sub, 10 = use funct.
- `exc`  out  1  one-cycle exception pulse for the cause register.
- `state`  out  4  current state code, for debug.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, j 000010. jr is R-type with funct 001000.
- Any output not listed for a state is 0.
- State codes are fixed: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BREX 8, ADDIEX 9, ADDIWB 10, JEX 11, JREX 12, EXC 13.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=000, irwrite=mem_ready, pcen=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state: lw/sw→MEMADR; R-type→RTYPEEX; R-type with jr funct→JREX; beq/bne→BREX; addi→ADDIEX; j→JEX; any other op→EXC.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw→MEMRD, sw→MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR: iord=1, memwrite=1, held for every cycle spent waiting. Goes to FETCH in the cycle mem_ready=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BREX: alusrca=1, alusrcb=00, aluop=01, pcsrc=001. pcen=zero for beq, pcen=~zero for bne. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JEX: pcsrc=010, pcen=1. Then FETCH.
- JREX: pcsrc=011, pcen=1. Then FETCH.
- EXC: pcsrc=100, pcen=1, exc=1. Then FETCH.
- Codes 14 and 15 are illegal: all outputs 0, next state FETCH.

## Timing
- Reset:
  - While rst_n=0 at an edge, the state becomes FETCH.
  - While rst_n=0, every output is forced to 0 combinationally, including pcen, irwrite, memwrite and regwrite.
  - A reset asserted mid-instruction abandons that instruction. No enable fires in the reset cycle.
- Outputs are Moore decodes of state, except three combinational terms: pcen/irwrite in FETCH (gated by mem_ready) and pcen in BREX (gated by zero).
- Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, jr 3, illegal op 3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes are held stable throughout the wait.

## Test plan
- Reset: hold rst_n=0 for 3 cycles while in MEMWR with mem_ready=0 → all outputs 0 during reset; state=0 after the first reset edge; memwrite never observed high while rst_n=0.
- lw, mem_ready=1: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; pcen=1 only in state 0.
- sw with mem_ready low for 2 cycles in MEMWR: state 5 held 3 cycles with memwrite=1 and iord=1; next state 0.
- beq with zero=1 → pcen=1, pcsrc=001 in state 8. bne with zero=1 → pcen=0 in state 8.
- j, then jr (op 000000, funct 001000): j gives state 11 with pcsrc=010, pcen=1; jr goes DECODE→state 12 with pcsrc=011, pcen=1.
- Illegal op 111111 → state 13 with exc=1, pcsrc=100, pcen=1 for one cycle, then state 0.
